// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - binary to BCD converter with sign/blanking and 4-digit scan multiplexer
module disp_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [13:0] value,
    input  logic        neg,
    input  logic        blank_lz,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bcd,
    output logic [3:0]  dig
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FMT
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [13:0]   shreg;
    logic [15:0]   work;
    logic [15:0]   work_adj;
    logic [3:0]    iter;
    logic          neg_r;
    logic          blank_r;
    logic          ovf_r;
    logic          done_r;
    logic [3:0]    disp [4];
    logic [3:0]    fmt  [4];
    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic          pre_tc;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [15:0] add3(input logic [15:0] x);
        logic [15:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            if (x[4*i +: 4] >= 4'd5) begin
                y[4*i +: 4] = x[4*i +: 4] + 4'd3;
            end
        end
        return y;
    endfunction

    assign work_adj = add3(work);
    assign busy     = (state != S_IDLE);
    assign done     = done_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: 14 shift iterations, then one format cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (load) state_nx = S_CONV;
            S_CONV:  if (iter == 4'd13) state_nx = S_FMT;
            S_FMT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Sign placement and leading-zero blanking of the finished BCD word
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fmt[i] = work[4*i +: 4];
        end
        if (ovf_r) begin
            for (int i = 0; i < 4; i++) begin
                fmt[i] = CODE_MINUS;
            end
        end else begin
            if (blank_r) begin
                if (work[15:12] == 4'd0) fmt[3] = CODE_BLANK;
                if (work[15:8]  == 8'd0) fmt[2] = CODE_BLANK;
                if (work[15:4]  == 12'd0) fmt[1] = CODE_BLANK;
            end
            // Magnitude is at most 999 here, so the sign slot never holds a digit
            if (neg_r && (work != 16'd0)) begin
                if (!blank_r)                fmt[3] = CODE_MINUS;
                else if (work[11:8] != 4'd0) fmt[3] = CODE_MINUS;
                else if (work[7:4]  != 4'd0) fmt[2] = CODE_MINUS;
                else                         fmt[1] = CODE_MINUS;
            end
        end
    end

    // Capture, conversion datapath and atomic display update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            work    <= '0;
            iter    <= '0;
            neg_r   <= 1'b0;
            blank_r <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                disp[i] <= CODE_BLANK;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shreg   <= value;
                        neg_r   <= neg;
                        blank_r <= blank_lz;
                        ovf_r   <= (value > 14'd9999) || (neg && (value > 14'd999));
                        work    <= '0;
                        iter    <= '0;
                    end
                end
                S_CONV: begin
                    work  <= {work_adj[14:0], shreg[13]};
                    shreg <= {shreg[12:0], 1'b0};
                    iter  <= iter + 4'd1;
                end
                S_FMT: begin
                    for (int i = 0; i < 4; i++) begin
                        disp[i] <= fmt[i];
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pre_tc = (pre == PRE_MAX);
    assign idx_nx = pre_tc ? (idx + 2'd1) : idx;

    // Free-running scan; strobe and code are registered together to avoid ghosting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= 2'd0;
            dig <= 4'b0001;
            bcd <= CODE_BLANK;
        end else begin
            pre <= pre_tc ? '0 : (pre + PW'(1));
            idx <= idx_nx;
            dig <= 4'b0001 << idx_nx;
            bcd <= disp[idx_nx];
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed self-checking bench for disp_scan
module tb_disp_scan;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [13:0] value;
    logic        neg;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [3:0]  bcd;
    logic [3:0]  dig;

    int nvec = 0;
    int nerr = 0;

    disp_scan #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .neg      (neg),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .dig      (dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observe one full frame (16 cycles) and compare {d3,d2,d1,d0}
    task automatic read_frame(input string tag, input logic [15:0] exp);
        logic [3:0] got [4];
        logic       bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 4'hx;
        for (int i = 0; i < 16; i++) begin
            case (dig)
                4'b0001: got[0] = bcd;
                4'b0010: got[1] = bcd;
                4'b0100: got[2] = bcd;
                4'b1000: got[3] = bcd;
                default: bad = 1'b1;
            endcase
            @(negedge clk);
        end
        check({tag, " onehot_bad"}, {15'd0, bad}, 16'd0);
        check({tag, " digits"}, {got[3], got[2], got[1], got[0]}, exp);
    endtask

    // Issue a load, then check busy/done for 16 cycles; optional second load at slot inj
    task automatic run_conv(input string tag, input logic [13:0] v, input logic n,
                            input logic b, input int inj, input logic [13:0] injv);
        @(negedge clk);
        value = v; neg = n; blank_lz = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == inj) begin
                load  = 1'b1;
                value = injv;
            end
            if (k == inj + 1) load = 1'b0;
            check({tag, " busy"}, {15'd0, busy}, (k < 15) ? 16'd1 : 16'd0);
            check({tag, " done"}, {15'd0, done}, (k == 15) ? 16'd1 : 16'd0);
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; load = 1'b0; value = 14'd0; neg = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", {15'd0, busy}, 16'd0);
        check("rst done", {15'd0, done}, 16'd0);
        check("rst dig",  {12'd0, dig},  16'h0001);
        check("rst bcd",  {12'd0, bcd},  16'h000F);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("idle dig", {12'd0, dig}, 16'd1 << ((i / 4) % 4));
            check("idle bcd", {12'd0, bcd}, 16'h000F);
            @(negedge clk);
        end

        run_conv("1234", 14'd1234, 1'b0, 1'b0, -1, 14'd0);
        read_frame("1234", 16'h1234);
        run_conv("42bl", 14'd42, 1'b0, 1'b1, -1, 14'd0);
        read_frame("42bl", 16'hFF42);
        run_conv("m7bl", 14'd7, 1'b1, 1'b1, -1, 14'd0);
        read_frame("m7bl", 16'hFFA7);
        run_conv("m0bl", 14'd0, 1'b1, 1'b1, -1, 14'd0);
        read_frame("m0bl", 16'hFFF0);
        run_conv("m7", 14'd7, 1'b1, 1'b0, -1, 14'd0);
        read_frame("m7", 16'hA007);
        run_conv("m305bl", 14'd305, 1'b1, 1'b1, -1, 14'd0);
        read_frame("m305bl", 16'hA305);
        run_conv("ovf10000", 14'd10000, 1'b0, 1'b0, -1, 14'd0);
        read_frame("ovf10000", 16'hAAAA);
        run_conv("ovfm1000", 14'd1000, 1'b1, 1'b0, -1, 14'd0);
        read_frame("ovfm1000", 16'hAAAA);
        run_conv("m999", 14'd999, 1'b1, 1'b0, -1, 14'd0);
        read_frame("m999", 16'hA999);
        run_conv("9999", 14'd9999, 1'b0, 1'b0, -1, 14'd0);
        read_frame("9999", 16'h9999);

        run_conv("coll", 14'd1234, 1'b0, 1'b0, 4, 14'd5555);
        read_frame("coll", 16'h1234);

        run_conv("e16a", 14'd1234, 1'b0, 1'b0, 15, 14'd5555);
        check("e16 accepted busy", {15'd0, busy}, 16'd1);
        repeat (15) @(negedge clk);
        check("e16 done", {15'd0, done}, 16'd1);
        check("e16 busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        read_frame("e16", 16'h5555);

        @(negedge clk);
        value = 14'd9999; neg = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst busy", {15'd0, busy}, 16'd0);
        check("mid rst done", {15'd0, done}, 16'd0);
        check("mid rst dig",  {12'd0, dig},  16'h0001);
        check("mid rst bcd",  {12'd0, bcd},  16'h000F);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("mid rst no done", {15'd0, saw_done}, 16'd0);
        check("mid rst idle", {15'd0, busy}, 16'd0);
        read_frame("mid rst", 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
# disp_scan

Sequential front end for the 7-segment display path. It accepts a binary value, converts it to four BCD digits with a shift-add-3 (double-dabble) engine, and applies leading-zero blanking and a minus sign. It then time-multiplexes the four digits onto one 4-bit code bus with a one-hot digit strobe. Output `bcd` feeds the BCD-to-segment decoder directly. Code 4'hA there renders "-", and any code 4'hB–4'hF renders all segments off.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is held during scanning. Must be ≥ 2.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: start conversion. Sampled only while `busy`=0.
- `value` in 14: unsigned magnitude, captured on an accepted `load`.
- `neg` in 1: display as negative. Captured with `value`.
- `blank_lz` in 1: enable leading-zero blanking. Captured with `value`.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse when the new digits take effect.
- `bcd` out 4: code for the currently strobed digit.
- `dig` out 4: one-hot digit strobe. `dig[0]` is the rightmost digit.

## Operation
- **Reset values.** `busy`=0, `done`=0, all four display registers = 4'hF (blank), scan index = 0, `dig`=4'b0001, `bcd`=4'hF, prescaler = 0.
- **States.**
  - IDLE → CONV on `load`=1. On that edge, capture `value`, `neg`, `blank_lz` and zero the working BCD register.
  - CONV runs 14 iterations, one per clock. Each iteration first adds 3 to every nibble ≥ 5, then shifts one value bit (MSB first) into the BCD register.
  - CONV → FMT after the 14th iteration.
  - FMT writes the formatted digits into the display registers, then returns to IDLE.
- **Overflow.** Overflow is `value` > 9999, or `neg`=1 with `value` > 999.
  - It is evaluated at capture.
  - Conversion still runs with identical timing.
  - FMT then writes 4'hA to all four digits ("----").
- **Formatting.** Applied in FMT when there is no overflow.
  - If `blank_lz`=1, digits d3, d2, d1 (scanned from d3 downward) are replaced by 4'hF while they are zero. Blanking stops at the first nonzero digit. d0 is never blanked.
  - If `neg`=1 and the magnitude ≠ 0, 4'hA is placed one position left of the most significant nonzero digit (d3 when `blank_lz`=0). That position is always free because magnitude ≤ 999.
  - A negative zero displays as a plain 0.
- **Load handling.**
  - `load` while `busy`=1 is ignored; it is neither queued nor restarts the conversion.
  - Changes to `value`, `neg`, `blank_lz` after capture have no effect on the conversion in progress.
- **Display update is atomic.** All four display registers change on the same edge. The old digits remain displayed throughout CONV.
- **Scan.**
  - The prescaler counts 0..`SCAN_DIV`-1 continuously, independent of conversion.
  - At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
  - `dig` = one-hot(index). `bcd` = display[index].
  - Both are registered and change on the same edge, so there is no ghosting.
  - A display update mid-scan shows on `bcd` from the next edge, at the current index.
- **Reset mid-operation.** Aborts any conversion immediately and returns every output to its reset value.

## Timing
- `load` accepted at edge E0:
  - `busy`=1 from E0 to E15 (15 cycles: 14 CONV + 1 FMT).
  - Display registers are written at E15.
  - `done`=1 for exactly one cycle, from E15 to E16; `busy`=0 in that same cycle.
- Back-to-back throughput: a new `load` is first accepted at E16, since `load` at E15 is seen with `busy`=0 only after E15.
- Latency from `load` to new `bcd`: 16 edges.
- Each digit is held for exactly `SCAN_DIV` cycles. The full frame is 4·`SCAN_DIV` cycles.

## Test plan
- **Reset defaults.** Release reset with `SCAN_DIV`=4 and no load → `bcd`=4'hF at every index, `dig` cycles 0001→0010→0100→1000→0001, 4 cycles per digit.
- **Plain conversion.** `load` with `value`=1234, `blank_lz`=0, `neg`=0 → `busy` high 15 cycles, `done` pulse at E15. Scan then reads d0..d3 = 4,3,2,1.
- **Blanking and sign.**
  - `value`=42, `blank_lz`=1 → F,F,4,2 (d3..d0).
  - `value`=7, `neg`=1, `blank_lz`=1 → F,F,A,7.
  - `value`=0, `neg`=1, `blank_lz`=1 → F,F,F,0.
- **Overflow.**
  - `value`=10000 → A,A,A,A after 15 cycles.
  - `value`=1000 with `neg`=1 → A,A,A,A.
  - `value`=9999 → 9,9,9,9.
- **Load collision.** Second `load` (`value`=5555) at E5 of a 1234 conversion → ignored, result is 1234, single `done` pulse. A `load` at E16 is accepted.
- **Reset mid-conversion.** Assert `rst_n`=0 at E7 of a conversion → `busy`, `done` = 0 immediately, display blank, `dig`=0001. No `done` pulse after release.
